// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator for a Sobel stage: two line buffers feed a
// 3x3 column shift register, and only interior-centred windows are flagged valid.
module sobel_window_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               in_ready,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  output logic [9:0]         win_col,
  output logic [8:0]         win_row,
  output logic               frame_done
);

  localparam int         AW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] ROW_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [9:0]       col;
  logic [8:0]       row;
  logic             accept;
  logic             last_pix;
  logic [AW-1:0]    idx;
  logic [PIX_W-1:0] lb0 [H_ACTIVE];
  logic [PIX_W-1:0] lb1 [H_ACTIVE];
  logic [PIX_W-1:0] win [9];

  // Reset is folded in so nothing is accepted or written while it is held.
  assign accept   = in_valid && (state == RUN) && !reset;
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign idx      = col[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        in_ready = !reset;
        if (accept && last_pix) state_next = DONE;
      end
      DONE: begin
        frame_done = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 9'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // Line buffers are deliberately unreset: rows 0/1 are rewritten before use.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= in_pixel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      win_valid <= accept && (row >= 9'd2) && (col >= 10'd2);
      if (accept) begin
        win_row <= row - 9'd1;
        win_col <= col - 10'd1;
        win[0]  <= win[1];
        win[1]  <= win[2];
        win[2]  <= lb1[idx];
        win[3]  <= win[4];
        win[4]  <= win[5];
        win[5]  <= lb0[idx];
        win[6]  <= win[7];
        win[7]  <= win[8];
        win[8]  <= in_pixel;
      end
    end
  end

  assign win_data = {win[0], win[1], win[2], win[3], win[4],
                     win[5], win[6], win[7], win[8]};

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on an 8x6 frame: the driver pushes
// windows computed from a reference image, the monitor pops on win_valid.
module tb_sobel_window_gen;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset, start, in_valid;
  logic [PW-1:0] in_pixel;
  logic          in_ready, win_valid, frame_done;
  logic [9*PW-1:0] win_data;
  logic [9:0]    win_col;
  logic [8:0]    win_row;

  sobel_window_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_pixel(in_pixel), .in_ready(in_ready), .win_valid(win_valid),
    .win_data(win_data), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [35:0] data;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;
  int          win_count = 0;
  logic        acc_now = 1'b0;
  logic        first_seen = 1'b1;
  logic [35:0] first_data;
  logic [8:0]  first_row;
  logic [9:0]  first_col;

  function automatic logic [3:0] pix(input int sel, input int r, input int c);
    if (sel == 0) pix = 4'((r * 8 + c) % 16);
    else          pix = 4'((r * 5 + c * 3 + 7) % 16);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs sampled just after the rising edge.
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (win_valid) begin
      win_count++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_data = win_data;
        first_row  = win_row;
        first_col  = win_col;
      end
      chk("win_after_accept", 64'(acc_now), 64'd1);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window actual row=%0d col=%0d required none", win_row, win_col);
      end else begin
        e = q.pop_front();
        chk("win_data", 64'(win_data), 64'(e.data));
        chk("win_row", 64'(win_row), 64'(e.row));
        chk("win_col", 64'(win_col), 64'(e.col));
        chk("frame_done_with_last", 64'(frame_done), 64'(e.last));
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_no_window actual=1 required=0 t=%0t", $time);
    end
    if (frame_done) fd_count++;
  end

  // Drives one frame from a negedge; gap toggles in_valid 1,0,1,0; start is
  // re-pulsed at pixel start_at; the frame stops early before pixel abort_at.
  task automatic run_frame(input int sel, input bit gap, input int start_at, input int abort_at);
    int r = 0, c = 0, n = 0, cyc = 0;
    logic v;
    exp_t e;
    in_valid = 1'b0;
    start    = 1'b1;
    acc_now  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    start = 1'b0;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual in_ready=0 required 1");
      return;
    end
    while (n < H * V && n != abort_at && cyc < 1000) begin
      v        = gap ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      in_pixel = pix(sel, r, c);
      start    = (n == start_at);
      acc_now  = v && in_ready;
      if (acc_now) begin
        if (r >= 2 && c >= 2) begin
          e.data = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.data = {e.data[31:0], pix(sel, r - 2 + i, c - 2 + j)};
          e.row  = 9'(r - 1);
          e.col  = 10'(c - 1);
          e.last = (r == V - 1) && (c == H - 1);
          q.push_back(e);
        end
        n++;
        if (c == H - 1) begin c = 0; r++; end
        else c++;
      end
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    acc_now  = 1'b0;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual pixels=%0d required %0d", n, H * V);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_win_data", 64'(win_data), 64'd0);
    chk("rst_win_row", 64'(win_row), 64'd0);
    chk("rst_win_col", 64'(win_col), 64'd0);
  endtask

  task automatic finish_frame(input string name, input int win0, input int fd_exp);
    repeat (3) @(negedge clock);
    chk({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({name, "_windows"}, 64'(win_count - win0), 64'd24);
    chk({name, "_frame_done"}, 64'(fd_count), 64'(fd_exp));
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Back-to-back frame with hand-checked first window.
    first_seen = 1'b0;
    w0 = win_count;
    run_frame(0, 1'b0, -1, -1);
    finish_frame("plain", w0, 1);
    chk("first_win_data", 64'(first_data), 64'h0_1289_A012);
    chk("first_win_row", 64'(first_row), 64'd1);
    chk("first_win_col", 64'(first_col), 64'd1);

    // Gapped input.
    w0 = win_count;
    run_frame(0, 1'b1, -1, -1);
    finish_frame("gapped", w0, 2);

    // in_valid while idle must not be taken.
    in_valid = 1'b1;
    in_pixel = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
    end
    w0 = win_count;
    run_frame(1, 1'b0, -1, -1);
    finish_frame("idle_valid", w0, 3);

    // Abort after 20 pixels, then a full frame.
    run_frame(0, 1'b0, -1, 20);
    reset = 1'b1;
    in_valid = 1'b1;
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_no_frame_done", 64'(fd_count), 64'd3);
    chk("abort_queue_empty", 64'(q.size()), 64'd0);
    w0 = win_count;
    run_frame(1, 1'b0, -1, -1);
    finish_frame("after_abort", w0, 4);

    // Start re-pulsed mid-frame.
    w0 = win_count;
    run_frame(0, 1'b0, 10, -1);
    finish_frame("start_in_run", w0, 5);

    // Two frames back to back with different images.
    w0 = win_count;
    run_frame(0, 1'b0, -1, -1);
    run_frame(1, 1'b0, -1, -1);
    repeat (3) @(negedge clock);
    chk("b2b_queue_empty", 64'(q.size()), 64'd0);
    chk("b2b_windows", 64'(win_count - w0), 64'd48);
    chk("b2b_frame_done", 64'(fd_count), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter PIX_W, default 4, meaning gray pixel width in bits.
REQ-004 The block SHALL have port clock, input, 1, the clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-006 The block SHALL have port start, input, 1, a frame start request.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_pixel carries a valid raster-order pixel.
REQ-008 The block SHALL have port in_pixel, input, PIX_W, the gray pixel.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the block accepts pixels.
REQ-010 The block SHALL have port win_valid, output, 1, meaning win_data holds a valid window.
REQ-011 The block SHALL have port win_data, output, 9*PIX_W, the 3x3 window a1..a9; a1 is in the MSBs, a9 in the LSBs.
REQ-012 The block SHALL have port win_col, output, 10, the column of the window centre.
REQ-013 The block SHALL have port win_row, output, 9, the row of the window centre.
REQ-014 The block SHALL have port frame_done, output, 1, a one-cycle end-of-frame pulse.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE SHALL move to RUN when start=1, and SHALL clear the column and row counters on that transition.
REQ-017 RUN SHALL move to DONE on acceptance of pixel (V_ACTIVE-1, H_ACTIVE-1).
REQ-018 DONE SHALL move to IDLE unconditionally after 1 cycle, with frame_done=1 for that cycle.
REQ-019 in_ready SHALL be 1 only in RUN; acceptance is in_valid AND in_ready.
REQ-020 In IDLE and DONE, in_valid SHALL be ignored and no state SHALL change.
REQ-021 start SHALL be ignored in RUN and DONE.
REQ-022 The column counter SHALL advance on each accepted pixel and wrap at H_ACTIVE-1 to 0.
REQ-023 The row counter SHALL increment on each column wrap.
REQ-024 The block SHALL contain two line buffers of H_ACTIVE x PIX_W, indexed by column.
REQ-025 On acceptance at column c, line buffer 1 [c] SHALL receive the old line buffer 0 [c], and line buffer 0 [c] SHALL receive in_pixel, in the same cycle.
REQ-026 The block SHALL hold a 3x3 shift register of columns: on acceptance, every row shifts left one column.
REQ-027 The new right column of the shift register SHALL be {line buffer 1 [c], line buffer 0 [c], in_pixel}, with top to bottom in that order.
REQ-028 For an accepted pixel at (r,c), a1 SHALL equal the pixel at (r-2,c-2) and a9 SHALL equal the pixel at (r,c), in row-major order.
REQ-029 win_valid SHALL be 1 exactly 1 cycle after acceptance of (r,c) when r>=2 and c>=2, and 0 otherwise.
REQ-030 win_row and win_col SHALL equal r-1 and c-1 in that same cycle.
REQ-031 Border pixels (rows 0 and V_ACTIVE-1, columns 0 and H_ACTIVE-1) SHALL produce no windows; there are exactly (H_ACTIVE-2)*(V_ACTIVE-2) windows per frame.
REQ-032 Windows SHALL never straddle a line wrap: the column shift register contents for c<2 are don't-care, and win_valid SHALL be suppressed for them.
REQ-033 Gaps in in_valid SHALL freeze all counters, buffers and the shift register, with win_valid=0 during the gap.
REQ-034 For the last pixel, win_valid and frame_done SHALL both be 1 in the same cycle (DONE).
REQ-035 Line buffer contents SHALL NOT need clearing between frames, because rows 0 and 1 are never emitted as a window's top rows before they are overwritten.

Reset
REQ-036 While reset=1, the block SHALL hold state=IDLE, counters=0, in_ready=0, win_valid=0, frame_done=0, win_data=0, win_row=0 and win_col=0.
REQ-037 reset SHALL take priority over start and in_valid.
REQ-038 reset mid-frame SHALL abort to IDLE with no frame_done; the next start SHALL begin a fresh frame at (0,0).
REQ-039 Line buffer RAM SHALL NOT need to be reset.

Verification
REQ-040 With H=8, V=6, start, then 48 back-to-back pixels valued (r*8+c) mod 16 -> 24 windows; the first has row=1, col=1, win_data={0,1,2,8,9,A,0,1,2}; frame_done fires in the cycle after pixel 47.
REQ-041 Same frame with in_valid toggling 1,0,1,0 -> identical window sequence and values, win_valid never 1 in the cycle after a 0 input.
REQ-042 in_valid=1 in IDLE with no start for 10 cycles, then start -> in_ready stays 0 while idle, and the first accepted pixel is counted as (0,0).
REQ-043 reset asserted after 20 pixels, then start and a full frame -> no frame_done before the restart, and the 24 windows are correct.
REQ-044 start pulsed during RUN at pixel 10 -> ignored, the counters continue, and the window count remains 24.
REQ-045 Two frames back-to-back (start asserted in the cycle after frame_done) -> the second frame's windows match the reference model, with no contamination from frame 1 data.
